// File: rtl/line_buf_scaler.sv
// Streaming N x N box-average downscaler (N = 1, 2, 3) with one line buffer of
// partial vertical sums per output column; syncs pass through with 1-clk latency.
module line_buf_scaler #(
    parameter int         DATA_W       = 10,
    parameter int         ADDR_W       = 10,
    parameter int         SUM_W        = DATA_W + 4,
    parameter logic [1:0] DEFAULT_MODE = 2'b00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_scale,
    input  logic              i_vsync,
    input  logic              i_hsync,
    input  logic              i_de,
    input  logic [DATA_W-1:0] i_red,
    input  logic [DATA_W-1:0] i_green,
    input  logic [DATA_W-1:0] i_blue,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic              o_de,
    output logic [DATA_W-1:0] o_red,
    output logic [DATA_W-1:0] o_green,
    output logic [DATA_W-1:0] o_blue,
    output logic [1:0]        o_mode,
    output logic              o_ovf
);

    typedef enum logic [1:0] {
        MODE_BYP   = 2'b00,
        MODE_HALF  = 2'b01,
        MODE_THIRD = 2'b10,
        MODE_BLANK = 2'b11
    } mode_e;

    // floor(x/9) == (x*RECIP) >> K for every x < 2**SUM_W because 9*RECIP - 2**K <= 8
    localparam int              K       = SUM_W + 4;
    localparam logic [63:0]     RECIP64 = ((64'd1 << K) / 64'd9) + 64'd1;
    localparam logic [K-1:0]    RECIP   = RECIP64[K-1:0];
    localparam logic [ADDR_W-1:0] XO_MAX = '1;

    logic              vsync_q, hsync_q, de_q, frame_ok_q, ovf_q, ode_q;
    mode_e             mode_q;
    logic [1:0]        hph_q, vph_q;
    logic [ADDR_W-1:0] xo_q;
    logic              xo_full_q;
    logic [DATA_W-1:0] out_q [3];

    logic              frame_ok_d, ovf_d, ode_d, xo_full_d;
    logic [1:0]        hph_d, vph_d;
    logic [ADDR_W-1:0] xo_d;
    logic [DATA_W-1:0] out_d [3];

    logic              vsync_rise, de_rise, de_fall, line_clr, frame_ok, scaled;
    mode_e             mode_cur;
    logic [1:0]        last_ph, hph_cur, vph_cur;
    logic [ADDR_W-1:0] xo_cur;
    logic              xo_full_cur, grp_done, col_ok, last_row, rd_en, wr_en, emit;

    logic [DATA_W-1:0]  pix [3];
    logic [DATA_W-1:0]  quo [3];
    logic [3*SUM_W-1:0] wr_data, rd_q;
    logic [3*SUM_W-1:0] line_mem [2**ADDR_W];

    assign pix[0] = i_red;
    assign pix[1] = i_green;
    assign pix[2] = i_blue;

    // Frame/line clears act on the current cycle so a pixel coinciding with them sees zeroed counters
    assign vsync_rise  = i_vsync & ~vsync_q;
    assign de_rise     = i_de & ~de_q;
    assign de_fall     = ~i_de & de_q;
    assign line_clr    = vsync_rise | de_rise;
    assign mode_cur    = vsync_rise ? mode_e'(i_scale) : mode_q;
    assign frame_ok    = vsync_rise | frame_ok_q;
    assign scaled      = (mode_cur == MODE_HALF) || (mode_cur == MODE_THIRD);
    assign last_ph     = (mode_cur == MODE_THIRD) ? 2'd2 : 2'd1;
    assign hph_cur     = line_clr ? 2'd0 : hph_q;
    assign vph_cur     = vsync_rise ? 2'd0 : vph_q;
    assign xo_cur      = line_clr ? '0 : xo_q;
    assign xo_full_cur = line_clr ? 1'b0 : xo_full_q;

    assign grp_done = i_de & scaled & (hph_cur == last_ph);
    assign rd_en    = i_de & scaled & (hph_cur == 2'd0);
    assign col_ok   = grp_done & ~xo_full_cur;
    assign last_row = (vph_cur == last_ph);
    assign wr_en    = col_ok & ~last_row;
    assign emit     = col_ok & last_row & frame_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [SUM_W-1:0]   pix_w, hsum, bsum, vsum;
            logic [SUM_W+K-1:0] vsum_x, recip_x, prod;
            logic [SUM_W-1:0]   hacc_q;
            logic               unused_bits;

            assign pix_w   = {{(SUM_W-DATA_W){1'b0}}, pix[gi]};
            assign hsum    = (hph_cur == 2'd0) ? pix_w : hacc_q + pix_w;
            assign bsum    = rd_q[gi*SUM_W +: SUM_W];
            assign vsum    = bsum + hsum;
            assign wr_data[gi*SUM_W +: SUM_W] = (vph_cur == 2'd0) ? hsum : vsum;
            assign vsum_x  = {{K{1'b0}}, vsum};
            assign recip_x = {{SUM_W{1'b0}}, RECIP};
            assign prod    = vsum_x * recip_x;
            assign quo[gi] = (mode_cur == MODE_THIRD) ? prod[K +: DATA_W] : vsum[2 +: DATA_W];
            assign unused_bits = ^{prod[SUM_W+K-1:K+DATA_W], prod[K-1:0],
                                   vsum[SUM_W-1:DATA_W+2], vsum[1:0]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hacc_q <= '0;
                end else if (i_de) begin
                    hacc_q <= hsum;
                end
            end
        end
    endgenerate

    always_comb begin
        frame_ok_d = frame_ok;
        hph_d      = hph_cur;
        vph_d      = vph_cur;
        xo_d       = xo_cur;
        xo_full_d  = xo_full_cur;
        ovf_d      = vsync_rise ? 1'b0 : ovf_q;
        ode_d      = 1'b0;
        for (int c = 0; c < 3; c++) begin
            out_d[c] = '0;
        end

        if (i_de && scaled) begin
            hph_d = (hph_cur == last_ph) ? 2'd0 : hph_cur + 2'd1;
        end
        // Column address saturates at the last entry; later groups in the line are dropped
        if (col_ok) begin
            if (xo_cur == XO_MAX) begin
                xo_full_d = 1'b1;
            end else begin
                xo_d = xo_cur + ADDR_W'(1);
            end
        end
        if (grp_done && xo_full_cur) begin
            ovf_d = 1'b1;
        end
        if (de_fall && !vsync_rise && scaled) begin
            vph_d = (vph_cur >= last_ph) ? 2'd0 : vph_cur + 2'd1;
        end

        case (mode_cur)
            MODE_BYP: begin
                if (i_de && frame_ok) begin
                    ode_d = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        out_d[c] = pix[c];
                    end
                end
            end
            MODE_HALF, MODE_THIRD: begin
                if (emit) begin
                    ode_d = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        out_d[c] = quo[c];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            de_q       <= 1'b0;
            mode_q     <= mode_e'(DEFAULT_MODE);
            frame_ok_q <= 1'b0;
            hph_q      <= '0;
            vph_q      <= '0;
            xo_q       <= '0;
            xo_full_q  <= 1'b0;
            ovf_q      <= 1'b0;
            ode_q      <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                out_q[c] <= '0;
            end
        end else begin
            vsync_q    <= i_vsync;
            hsync_q    <= i_hsync;
            de_q       <= i_de;
            mode_q     <= mode_cur;
            frame_ok_q <= frame_ok_d;
            hph_q      <= hph_d;
            vph_q      <= vph_d;
            xo_q       <= xo_d;
            xo_full_q  <= xo_full_d;
            ovf_q      <= ovf_d;
            ode_q      <= ode_d;
            for (int c = 0; c < 3; c++) begin
                out_q[c] <= out_d[c];
            end
        end
    end

    // Line buffer: registered read issued on a group's first pixel, holds until its last
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[xo_cur] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= line_mem[xo_cur];
        end
    end

    assign o_vsync = vsync_q;
    assign o_hsync = hsync_q;
    assign o_de    = ode_q;
    assign o_red   = out_q[0];
    assign o_green = out_q[1];
    assign o_blue  = out_q[2];
    assign o_mode  = mode_q;
    assign o_ovf   = ovf_q;

endmodule
